sram62256_arbiter: RTL and testbench

// - Synchronous two-port controller/arbiter for one 32Kx8 asynchronous SRAM (62256-class).
// - Shares the SRAM between port 0 (CPU side) and port 1 (DMA/video side).
// - Sequences ncs/noe/nwe with programmable access width and drives a split data bus (top level builds the inout).

---
 rtl/sram62256_arbiter.sv | 128 ++++++++++++
 tb/tb_sram62256_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram62256_arbiter.sv
// Two-port arbiter and strobe sequencer for one 32Kx8 asynchronous SRAM (62256-class).
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
`timescale 1ns/1ps
module sram62256_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [14:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [14:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  output logic        sram_ncs,
  output logic        sram_noe,
  output logic        sram_nwe,
  output logic [14:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        cur_port;
  logic        cur_we;
  logic        gnt;
  logic        gnt_we;
  logic [14:0] gnt_addr;
  logic [7:0]  gnt_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // ptr names the port preferred on a tie; it flips away from each winner
  logic ptr;
  always_comb gnt = (p0_req && p1_req) ? ptr : p1_req;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                    ptr <= 1'b0;
    else if (state == IDLE && (p0_req || p1_req)) ptr <= ~gnt;
  end
`else
  always_comb gnt = !p0_req;
`endif

  assign gnt_we    = gnt ? p1_we    : p0_we;
  assign gnt_addr  = gnt ? p1_addr  : p0_addr;
  assign gnt_wdata = gnt ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_port  <= 1'b0;
      cur_we    <= 1'b0;
      sram_ncs  <= 1'b1;
      sram_noe  <= 1'b1;
      sram_nwe  <= 1'b1;
      sram_doe  <= 1'b0;
      sram_addr <= '0;
      sram_dout <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          sram_ncs <= 1'b1;
          sram_noe <= 1'b1;
          sram_nwe <= 1'b1;
          sram_doe <= 1'b0;
          // address and data are captured only here, so they never move while ncs is low
          if (p0_req || p1_req) begin
            cur_port  <= gnt;
            cur_we    <= gnt_we;
            sram_addr <= gnt_addr;
            sram_dout <= gnt_wdata;
            sram_ncs  <= 1'b0;
            sram_noe  <= gnt_we;
            sram_doe  <= gnt_we;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cnt      <= CNT_LOAD;
          sram_nwe <= !cur_we;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            sram_ncs <= 1'b1;
            sram_noe <= 1'b1;
            sram_nwe <= 1'b1;
            p0_ack   <= !cur_port;
            p1_ack   <= cur_port;
            if (!cur_we) begin
              if (cur_port) p1_rdata <= sram_din;
              else          p0_rdata <= sram_din;
            end
            state <= RECOVER;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: begin
          // doe released only now so write data outlives the rising edge of nwe
          sram_doe <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram62256_arbiter.sv
// Self-checking bench for sram62256_arbiter: 62256 behavioural model plus a memory/arbitration reference.
`timescale 1ns/1ps
module tb_sram62256_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [14:0] p0_addr = '0;
  logic [7:0]  p0_wdata = '0;
  logic        p0_ack;
  logic [7:0]  p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [14:0] p1_addr = '0;
  logic [7:0]  p1_wdata = '0;
  logic        p1_ack;
  logic [7:0]  p1_rdata;
  logic        sram_ncs, sram_noe, sram_nwe, sram_doe;
  logic [14:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;

  int checks = 0;
  int failures = 0;
  int tb_last = -1;

  logic [7:0] sram_mem [0:32767];
  logic [7:0] ref_mem  [0:32767];
  int hi_run = 0;
  int last_gap = 0;

  sram62256_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .nrst(nrst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_ncs(sram_ncs), .sram_noe(sram_noe), .sram_nwe(sram_nwe),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din)
  );

  always #50 clk = ~clk;

  // 62256 model: reads drive data while selected and output-enabled, writes land while ncs/nwe low
  assign sram_din = (!sram_ncs && !sram_noe) ? sram_mem[sram_addr] : 8'hxx;
  always @(negedge clk) if (!sram_ncs && !sram_nwe) sram_mem[sram_addr] <= sram_dout;

  always @(negedge clk) begin
    if (sram_ncs) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // preferred port on a tie: round robin prefers the port not served last, fixed prefers port 0
  function automatic bit pref_port();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    return (tb_last == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_access(input bit port, input bit we, input logic [14:0] addr,
                           input logic [7:0] wd, output int lat, output int nwe_lo,
                           output logic [7:0] rd, output logic [7:0] exp_rd);
    @(negedge clk);
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    lat = -1; nwe_lo = 0; rd = 'x; exp_rd = 'x;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!sram_nwe) nwe_lo++;
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        lat = c;
        rd = port ? p1_rdata : p0_rdata;
        if (we) ref_mem[addr] = wd;
        exp_rd = ref_mem[addr];
        tb_last = port;
        break;
      end
    end
    if (port) p1_req = 0; else p0_req = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sram_ncs !== 1 || sram_noe !== 1 || sram_nwe !== 1) begin failures++;
      $display("FAIL reset_strobes got ncs/noe/nwe=%b%b%b want 111", sram_ncs, sram_noe, sram_nwe); end
    checks++; if (sram_doe !== 0 || sram_addr !== 15'd0 || sram_dout !== 8'd0) begin failures++;
      $display("FAIL reset_bus got doe=%b addr=%h dout=%h want 0/0000/00", sram_doe, sram_addr, sram_dout); end
    checks++; if (p0_ack !== 0 || p1_ack !== 0 || p0_rdata !== 8'd0 || p1_rdata !== 8'd0) begin failures++;
      $display("FAIL reset_ports got ack=%b%b rdata=%h/%h want 00 00/00", p0_ack, p1_ack, p0_rdata, p1_rdata); end
    repeat (2) @(negedge clk);
    nrst = 1;
    tb_last = -1;
    repeat (2) @(negedge clk);
    checks++; if (sram_ncs !== 1 || sram_doe !== 0) begin failures++;
      $display("FAIL idle_after_reset got ncs=%b doe=%b want 1/0", sram_ncs, sram_doe); end
  endtask

  task automatic test_write_read();
    int lat, nlo; logic [7:0] rd, ex;
    do_access(0, 1, 15'h1234, 8'h5A, lat, nlo, rd, ex);
    checks++; if (lat != 4) begin failures++; $display("FAIL wr_latency got %0d want 4", lat); end
    checks++; if (nlo != 2) begin failures++; $display("FAIL wr_nwe_low got %0d want 2", nlo); end
    @(negedge clk);
    checks++; if (p0_ack !== 0) begin failures++; $display("FAIL ack_pulse got %b want 0", p0_ack); end
    do_access(0, 0, 15'h1234, 8'h00, lat, nlo, rd, ex);
    checks++; if (lat != 4) begin failures++; $display("FAIL rd_latency got %0d want 4", lat); end
    checks++; if (nlo != 0) begin failures++; $display("FAIL rd_nwe_low got %0d want 0", nlo); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd_data got %h want 5a", rd); end
  endtask

  task automatic test_simultaneous();
    int l0, l1, n0, n1; logic [7:0] r0, r1, e0, e1; bit w;
    w = pref_port();
    fork
      do_access(0, 1, 15'h0000, 8'h11, l0, n0, r0, e0);
      do_access(1, 1, 15'h7FFF, 8'h22, l1, n1, r1, e1);
    join
    checks++; if (l0 != (w ? 9 : 4) || l1 != (w ? 4 : 9)) begin failures++;
      $display("FAIL simul_wr_order got lat0=%0d lat1=%0d want winner p%0d", l0, l1, w); end
    w = pref_port();
    fork
      do_access(0, 0, 15'h0000, 8'h00, l0, n0, r0, e0);
      do_access(1, 0, 15'h7FFF, 8'h00, l1, n1, r1, e1);
    join
    checks++; if (l0 != (w ? 9 : 4) || l1 != (w ? 4 : 9)) begin failures++;
      $display("FAIL simul_rd_order got lat0=%0d lat1=%0d want winner p%0d", l0, l1, w); end
    checks++; if (r0 !== 8'h11 || r1 !== 8'h22) begin failures++;
      $display("FAIL simul_rd_data got %h/%h want 11/22", r0, r1); end
  endtask

  task automatic test_starve();
    int n0_early = 0, n1_early = 0, n0 = 0, p1_at = -1, bad = 0;
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 15'h0000;
    p1_req = 1; p1_we = 0; p1_addr = 15'h7FFF;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (p0_ack === 1'b1) begin
        n0++; if (c <= 12) n0_early++; tb_last = 0;
        if (p0_rdata !== ref_mem[0]) bad++;
      end
      if (p1_ack === 1'b1) begin
        p1_at = c; if (c <= 12) n1_early++; tb_last = 1; p1_req = 0;
        if (p1_rdata !== ref_mem[15'h7FFF]) bad++;
      end
      if (c == 12) p0_req = 0;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL starve_data got %0d bad reads want 0", bad); end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    checks++; if (n0_early != 1 || n1_early != 1) begin failures++;
      $display("FAIL rr_alternate got p0=%0d p1=%0d acks want 1/1", n0_early, n1_early); end
    checks++; if (n0 != 2) begin failures++; $display("FAIL rr_total got %0d p0 acks want 2", n0); end
`else
    checks++; if (n1_early != 0 || n0_early != 2) begin failures++;
      $display("FAIL fixed_starve got p0=%0d p1=%0d acks want 2/0", n0_early, n1_early); end
    checks++; if (p1_at != 19 || n0 != 3) begin failures++;
      $display("FAIL fixed_release got p1 ack at %0d p0 acks %0d want 19/3", p1_at, n0); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, nlo, seen = 0; logic [7:0] rd, ex;
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 15'h0100; p0_wdata = 8'h77;
    repeat (2) @(negedge clk);
    checks++; if (sram_nwe !== 0) begin failures++; $display("FAIL mid_pre_nwe got %b want 0", sram_nwe); end
    #10 nrst = 0;
    #1;
    checks++; if (sram_ncs !== 1 || sram_noe !== 1 || sram_nwe !== 1 || sram_doe !== 0) begin failures++;
      $display("FAIL mid_reset got ncs/noe/nwe/doe=%b%b%b%b want 1110", sram_ncs, sram_noe, sram_nwe, sram_doe); end
    p0_req = 0;
    tb_last = -1;
    repeat (2) @(negedge clk);
    nrst = 1;
    repeat (6) begin @(negedge clk); if (p0_ack === 1'b1 || p1_ack === 1'b1) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_ack got %0d acks want 0", seen); end
    do_access(0, 1, 15'h0101, 8'hC3, lat, nlo, rd, ex);
    do_access(0, 0, 15'h0101, 8'h00, lat, nlo, rd, ex);
    checks++; if (lat != 4 || rd !== 8'hC3) begin failures++;
      $display("FAIL mid_recover got lat=%0d data=%h want 4/c3", lat, rd); end
  endtask

  task automatic test_addr_change();
    int lat, nlo, bad = 0, acked = 0; logic [7:0] rd, ex;
    do_access(0, 1, 15'h3333, 8'h0F, lat, nlo, rd, ex);
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 15'h2222; p0_wdata = 8'hA5;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin p0_addr = 15'h3333; p0_wdata = 8'hFF; end
      if (!sram_ncs && (sram_addr !== 15'h2222 || sram_dout !== 8'hA5)) bad++;
      if (p0_ack === 1'b1) begin acked = 1; p0_req = 0; break; end
    end
    p0_req = 0;
    ref_mem[15'h2222] = 8'hA5;
    tb_last = 0;
    checks++; if (bad != 0 || acked != 1) begin failures++;
      $display("FAIL hold_bus got %0d unstable cycles acked=%0d want 0/1", bad, acked); end
    do_access(0, 0, 15'h2222, 8'h00, lat, nlo, rd, ex);
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL hold_granted got %h want a5", rd); end
    do_access(0, 0, 15'h3333, 8'h00, lat, nlo, rd, ex);
    checks++; if (rd !== 8'h0F) begin failures++; $display("FAIL hold_other got %h want 0f", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, nlo; logic [7:0] rd, ex; time t_prev = 0, t_now;
    for (int a = 0; a < 4; a++)
      do_access(0, 1, 15'(a), 8'($urandom_range(0, 255)), lat, nlo, rd, ex);
    for (int a = 0; a < 4; a++) begin
      do_access(1, 0, 15'(a), 8'h00, lat, nlo, rd, ex);
      t_now = $time;
      checks++; if (rd !== ex) begin failures++; $display("FAIL b2b_data[%0d] got %h want %h", a, rd, ex); end
      if (a > 0) begin
        checks++; if (t_now - t_prev != 500) begin failures++;
          $display("FAIL b2b_spacing[%0d] got %0t want 500ns", a, t_now - t_prev); end
        checks++; if (last_gap < 2) begin failures++;
          $display("FAIL b2b_ncs_gap[%0d] got %0d want >=2", a, last_gap); end
      end
      t_prev = t_now;
    end
  endtask

  task automatic test_random();
    int l0, l1, n0, n1; logic [7:0] r0, r1, e0, e1; bit en0, en1, we0, we1, w;
    logic [14:0] a0, a1; logic [7:0] d0, d1;
    for (int a = 0; a < 16; a++)
      do_access(0, 1, 15'h4000 + 15'(a), 8'($urandom_range(0, 255)), l0, n0, r0, e0);
    for (int it = 0; it < 30; it++) begin
      en0 = 1'($urandom); en1 = 1'($urandom);
      if (!en0 && !en1) en0 = 1;
      we0 = 1'($urandom); we1 = 1'($urandom);
      a0 = 15'h4000 + 15'($urandom_range(0, 15)); a1 = 15'h4000 + 15'($urandom_range(0, 15));
      d0 = 8'($urandom); d1 = 8'($urandom);
      w = pref_port();
      l0 = 0; l1 = 0; r0 = 0; r1 = 0; e0 = 0; e1 = 0;
      fork
        begin if (en0) do_access(0, we0, a0, d0, l0, n0, r0, e0); end
        begin if (en1) do_access(1, we1, a1, d1, l1, n1, r1, e1); end
      join
      if (en0) begin
        checks++; if (l0 != ((en1 && w) ? 9 : 4)) begin failures++;
          $display("FAIL rand_lat0[%0d] got %0d want %0d", it, l0, (en1 && w) ? 9 : 4); end
        if (!we0) begin checks++; if (r0 !== e0) begin failures++;
          $display("FAIL rand_rd0[%0d] got %h want %h", it, r0, e0); end end
      end
      if (en1) begin
        checks++; if (l1 != ((en0 && !w) ? 9 : 4)) begin failures++;
          $display("FAIL rand_lat1[%0d] got %0d want %0d", it, l1, (en0 && !w) ? 9 : 4); end
        if (!we1) begin checks++; if (r1 !== e1) begin failures++;
          $display("FAIL rand_rd1[%0d] got %h want %h", it, r1, e1); end end
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_starve();
    test_reset_mid();
    test_addr_change();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
